// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   arb_state_t    : arbiter FSM states
//   ADDR_FOLD_MASK : clears byte-address bit 22 so the 0x0040_0000 text
//                    segment lands on word index 0
//   WORD_SHIFT     : byte address to word index shift
//   REQ_IF/REQ_LS  : requester identifiers used for grant and ack steering
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [31:0] ADDR_FOLD_MASK = 32'hFFBF_FFFF;
  localparam int          WORD_SHIFT     = 2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/addr_xlate.sv
// Byte-address to word-index translation for the memory port.
//   byte_addr  : MIPS byte address of the granted requester
//   word_idx   : folded, shifted word index (upper bits zero)
//   misaligned : high when the byte address is not word aligned
module addr_xlate
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] byte_addr,
  output logic [ADDR_WIDTH-1:0] word_idx,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] fold_mask;

  assign fold_mask  = ADDR_WIDTH'(ADDR_FOLD_MASK);
  assign word_idx   = (byte_addr & fold_mask) >> WORD_SHIFT;
  assign misaligned = |byte_addr[1:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one
// word-addressed memory port with a fixed read latency.
//   clk, reset                  : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request, held until if_ack
//   if_ack/if_rdata/if_err      : one-cycle completion, fetched word, misalign flag
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request, held until ls_ack
//   ls_ack/ls_rdata/ls_err      : one-cycle completion, load data, misalign flag
//   mem_en/mem_we/mem_addr/mem_wdata : memory access strobe, write enable, word index, data
//   mem_rdata                   : read data, valid MEM_LATENCY cycles after mem_en
//   busy                        : high whenever the arbiter is not idle
// Every output is a flop; requests only influence outputs one edge later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int                CNT_W    = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY);

  arb_state_t            state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;
  logic                  grant_id;

  logic                  grant_vld;
  logic                  grant_sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned;
  logic                  access_done;

  logic                  mem_en_d;
  logic                  busy_d;
  logic                  ack_d;
  logic                  ack_id_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  load_mem;

  // Grant selection: a tie goes to whichever side was not served last.
  always_comb begin
    grant_vld = if_req | ls_req;
    grant_sel = REQ_IF;
    if (if_req && ls_req) begin
      grant_sel = (last_grant == REQ_LS) ? REQ_IF : REQ_LS;
    end else if (ls_req) begin
      grant_sel = REQ_LS;
    end
    sel_addr = (grant_sel == REQ_LS) ? ls_addr : if_addr;
  end

  addr_xlate #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_xlate (
    .byte_addr  (sel_addr),
    .word_idx   (word_idx),
    .misaligned (misaligned)
  );

  // The counter reaches zero in the cycle mem_rdata becomes valid.
  assign access_done = (state == ACCESS) && (cnt == '0);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_IF;
      grant_id   <= REQ_IF;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_vld) begin
        last_grant <= grant_sel;
        grant_id   <= grant_sel;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- output logic (next values of the registered outputs) ----
  always_comb begin
    mem_en_d = 1'b0;
    busy_d   = (state_next != IDLE);
    ack_d    = 1'b0;
    ack_id_d = grant_id;
    err_d    = 1'b0;
    rdata_d  = '0;
    load_mem = 1'b0;
    case (state)
      IDLE: begin
        ack_id_d = grant_sel;
        if (grant_vld) begin
          if (misaligned) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            mem_en_d = 1'b1;
            load_mem = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (access_done) begin
          ack_d   = 1'b1;
          // Stores return zero; the port's read data is meaningless for them.
          rdata_d = mem_we ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // ---- output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_ack    <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en <= mem_en_d;
      busy   <= busy_d;
      if_ack <= ack_d && (ack_id_d == REQ_IF);
      ls_ack <= ack_d && (ack_id_d == REQ_LS);
      // rdata/err only change with their own ack and hold otherwise.
      if (ack_d && ack_id_d == REQ_IF) begin
        if_rdata <= rdata_d;
        if_err   <= err_d;
      end
      if (ack_d && ack_id_d == REQ_LS) begin
        ls_rdata <= rdata_d;
        ls_err   <= err_d;
      end
      // Port address/data stay stable for the whole access; fetches never write.
      if (load_mem) begin
        mem_addr  <= word_idx;
        mem_we    <= (grant_sel == REQ_LS) && ls_we;
        mem_wdata <= (grant_sel == REQ_LS) ? ls_wdata : '0;
      end
    end
  end

endmodule
